// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator: sync/back porch/active/front porch raster with
// colourbar, grid, gradient and solid modes. Define VPG_SCROLL_EN for a per-frame scrolling colourbar.
module video_pattern_gen #(
    parameter int unsigned H_SYNC  = 40,
    parameter int unsigned H_BACK  = 220,
    parameter int unsigned H_DISP  = 1280,
    parameter int unsigned H_FRONT = 110,
    parameter int unsigned V_SYNC  = 5,
    parameter int unsigned V_BACK  = 20,
    parameter int unsigned V_DISP  = 720,
    parameter int unsigned V_FRONT = 5,
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned CNT_W   = 12
) (
    input  logic                   pixel_clk,
    input  logic                   sys_rst,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   video_hs,
    output logic                   video_vs,
    output logic                   video_de,
    output logic [3*COLOR_W-1:0]   video_rgb,
    output logic [CNT_W-1:0]       pixel_xpos,
    output logic [CNT_W-1:0]       pixel_ypos,
    output logic                   frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
    localparam int unsigned H_ACT1  = H_ACT0 + H_DISP;
    localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
    localparam int unsigned V_ACT1  = V_ACT0 + V_DISP;
    localparam int unsigned BAR_W   = H_DISP / 8;
    localparam int unsigned RGB_W   = 3 * COLOR_W;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [1:0]       mode_q;
    logic [RGB_W-1:0] solid_q;
    logic             h_last_c;
    logic             v_last_c;
    logic             origin_c;

    assign h_last_c = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last_c = (v_cnt == CNT_W'(V_TOTAL - 1));
    assign origin_c = (h_cnt == '0) && (v_cnt == '0);

    // Raster counters
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last_c) begin
            h_cnt <= '0;
            v_cnt <= v_last_c ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Pattern controls only change on the frame origin so a frame is never mixed
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (origin_c) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

`ifdef VPG_SCROLL_EN
    localparam int unsigned SUM_W = CNT_W + 1;
    logic [CNT_W-1:0] offset_q;
    logic [SUM_W-1:0] col_sum_c;

    // Offset steps on the transition into each new frame
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            offset_q <= '0;
        end else if (h_last_c && v_last_c) begin
            offset_q <= (offset_q == CNT_W'(H_DISP - 1)) ? '0 : offset_q + CNT_W'(1);
        end
    end
`endif

    logic             hs_c;
    logic             vs_c;
    logic             de_c;
    logic [CNT_W-1:0] x_c;
    logic [CNT_W-1:0] y_c;
    logic [CNT_W-1:0] col_c;
    logic [CNT_W-1:0] bar_idx_c;
    logic [2:0]       bar_c;
    logic [RGB_W-1:0] pix_c;
    logic [RGB_W-1:0] rgb_c;

    // Timing decode and pattern generation from the current counter state
    always_comb begin
        hs_c      = (h_cnt < CNT_W'(H_SYNC));
        vs_c      = (v_cnt < CNT_W'(V_SYNC));
        de_c      = (h_cnt >= CNT_W'(H_ACT0)) && (h_cnt < CNT_W'(H_ACT1)) &&
                    (v_cnt >= CNT_W'(V_ACT0)) && (v_cnt < CNT_W'(V_ACT1));
        x_c       = de_c ? h_cnt - CNT_W'(H_ACT0) : '0;
        y_c       = de_c ? v_cnt - CNT_W'(V_ACT0) : '0;
`ifdef VPG_SCROLL_EN
        col_sum_c = {1'b0, x_c} + {1'b0, offset_q};
        col_c     = (col_sum_c >= SUM_W'(H_DISP)) ? CNT_W'(col_sum_c - SUM_W'(H_DISP))
                                                  : CNT_W'(col_sum_c);
`else
        col_c     = x_c;
`endif
        bar_idx_c = col_c / CNT_W'(BAR_W);
        bar_c     = (bar_idx_c > CNT_W'(7)) ? 3'd7 : bar_idx_c[2:0];
        pix_c     = '0;
        unique case (mode_q)
            2'd0: pix_c = {{COLOR_W{~bar_c[1]}}, {COLOR_W{~bar_c[2]}}, {COLOR_W{~bar_c[0]}}};
            2'd1: pix_c = ((x_c[3:0] == 4'd0) || (y_c[3:0] == 4'd0)) ? '1 : '0;
            2'd2: pix_c = {3{x_c[COLOR_W-1:0]}};
            2'd3: pix_c = solid_q;
        endcase
        rgb_c     = de_c ? pix_c : '0;
    end

    // Output register stage keeps every output one cycle behind the counters
    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            video_hs    <= 1'b0;
            video_vs    <= 1'b0;
            video_de    <= 1'b0;
            video_rgb   <= '0;
            pixel_xpos  <= '0;
            pixel_ypos  <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= hs_c;
            video_vs    <= vs_c;
            video_de    <= de_c;
            video_rgb   <= rgb_c;
            pixel_xpos  <= x_c;
            pixel_ypos  <= y_c;
            frame_start <= origin_c;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: three instances (default, medium, tiny timing) checked every
// cycle against a raster model, plus hand-computed pixel/timing literals.
module tb_video_pattern_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  mode_in  [3];
    logic [23:0] solid_in [3];

    logic        o_hs [3];
    logic        o_vs [3];
    logic        o_de [3];
    logic        o_fs [3];
    logic [23:0] o_rgb[3];
    logic [11:0] o_x  [3];
    logic [11:0] o_y  [3];

    int hs_w[3] = '{40, 4, 2};
    int hb_w[3] = '{220, 6, 2};
    int hd_w[3] = '{1280, 320, 20};
    int vs_w[3] = '{5, 2, 2};
    int vb_w[3] = '{20, 2, 2};
    int vd_w[3] = '{720, 24, 4};
    int htot[3] = '{1650, 340, 26};
    int vtot[3] = '{750, 30, 10};

    video_pattern_gen u_a (
        .pixel_clk(clk), .sys_rst(rst), .mode(mode_in[0]), .solid_rgb(solid_in[0]),
        .video_hs(o_hs[0]), .video_vs(o_vs[0]), .video_de(o_de[0]), .video_rgb(o_rgb[0]),
        .pixel_xpos(o_x[0]), .pixel_ypos(o_y[0]), .frame_start(o_fs[0])
    );

    video_pattern_gen #(
        .H_SYNC(4), .H_BACK(6), .H_DISP(320), .H_FRONT(10),
        .V_SYNC(2), .V_BACK(2), .V_DISP(24), .V_FRONT(2)
    ) u_b (
        .pixel_clk(clk), .sys_rst(rst), .mode(mode_in[1]), .solid_rgb(solid_in[1]),
        .video_hs(o_hs[1]), .video_vs(o_vs[1]), .video_de(o_de[1]), .video_rgb(o_rgb[1]),
        .pixel_xpos(o_x[1]), .pixel_ypos(o_y[1]), .frame_start(o_fs[1])
    );

    video_pattern_gen #(
        .H_SYNC(2), .H_BACK(2), .H_DISP(20), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(2)
    ) u_c (
        .pixel_clk(clk), .sys_rst(rst), .mode(mode_in[2]), .solid_rgb(solid_in[2]),
        .video_hs(o_hs[2]), .video_vs(o_vs[2]), .video_de(o_de[2]), .video_rgb(o_rgb[2]),
        .pixel_xpos(o_x[2]), .pixel_ypos(o_y[2]), .frame_start(o_fs[2])
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [23:0] bar_color(input int bar);
        case (bar)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Outputs the raster must show for counter position (h,v)
    function automatic out_t model(input int h, input int v, input int d, input int md,
                                   input logic [23:0] sol, input int off);
        out_t o;
        int x, y, col, bar;
        logic [7:0] g;
        o    = '0;
        o.hs = (h < hs_w[d]);
        o.vs = (v < vs_w[d]);
        o.fs = (h == 0) && (v == 0);
        x = h - hs_w[d] - hb_w[d];
        y = v - vs_w[d] - vb_w[d];
        if (x >= 0 && x < hd_w[d] && y >= 0 && y < vd_w[d]) begin
            o.de = 1'b1;
            o.x  = 12'(x);
            o.y  = 12'(y);
            case (md)
                0: begin
                    col = (x + off) % hd_w[d];
                    bar = col / (hd_w[d] / 8);
                    if (bar > 7) bar = 7;
                    o.rgb = bar_color(bar);
                end
                1: o.rgb = ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
                2: begin
                    g = 8'(x % 256);
                    o.rgb = {g, g, g};
                end
                default: o.rgb = sol;
            endcase
        end
        return o;
    endfunction

    int          mh[3], mv[3], cap_md[3], off[3];
    logic [23:0] cap_sol[3];
    out_t        exp_o[3];

    initial for (int d = 0; d < 3; d++) exp_o[d] = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                mh[d] <= 0; mv[d] <= 0; cap_md[d] <= 0; cap_sol[d] <= '0;
                off[d] <= 0; exp_o[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                exp_o[d] <= model(mh[d], mv[d], d, cap_md[d], cap_sol[d], off[d]);
                if (mh[d] == 0 && mv[d] == 0) begin
                    cap_md[d]  <= int'(mode_in[d]);
                    cap_sol[d] <= solid_in[d];
                end
                if (mh[d] == htot[d] - 1) begin
                    mh[d] <= 0;
                    if (mv[d] == vtot[d] - 1) begin
                        mv[d] <= 0;
`ifdef VPG_SCROLL_EN
                        off[d] <= (off[d] + 1) % hd_w[d];
`endif
                    end else begin
                        mv[d] <= mv[d] + 1;
                    end
                end else begin
                    mh[d] <= mh[d] + 1;
                end
            end
        end
    end

    int   ncyc = 0;
    int   hs_rise = -1;
    bit   hs_w_done = 0, hs_p_done = 0;
    logic prev_hs = 0, prev_de_a = 0, prev_de_b = 0;
    int   de_run = 0, b_lines = 0, b_fr = 0, c_fr = 0;

    always @(negedge clk) begin
        out_t act[3];
        for (int d = 0; d < 3; d++) begin
            act[d] = '{hs: o_hs[d], vs: o_vs[d], de: o_de[d], fs: o_fs[d],
                       rgb: o_rgb[d], x: o_x[d], y: o_y[d]};
            n_vec++;
            if (act[d] !== exp_o[d]) begin
                n_miss++;
                $display("FAIL model dut%0d cyc %0d: got %h want %h", d, ncyc, act[d], exp_o[d]);
            end
        end
        if (!rst) ncyc++;

        if (ncyc == 2) begin
            chk("first_frame_start", 32'(act[0].fs), 1);
            chk("first_vs", 32'(act[0].vs), 1);
        end
        if (ncyc == 3) chk("frame_start_width", 32'(act[0].fs), 0);

        // Default timing: hs width and period, de run length
        if (act[0].hs && !prev_hs) begin
            if (hs_rise >= 0 && !hs_p_done) begin
                chk("hs_period", 32'(ncyc - hs_rise), 1650);
                hs_p_done = 1;
            end
            hs_rise = ncyc;
        end
        if (!act[0].hs && prev_hs && !hs_w_done) begin
            chk("hs_width", 32'(ncyc - hs_rise), 40);
            hs_w_done = 1;
        end
        prev_hs = act[0].hs;
        if (act[0].de) de_run++;
        else if (prev_de_a) begin
            chk("de_run", 32'(de_run), 1280);
            de_run = 0;
        end
        prev_de_a = act[0].de;

        if (act[0].de && act[0].y == 0) begin
            case (act[0].x)
                12'd0:    chk("bar_x0", 32'(act[0].rgb), 32'hFFFFFF);
                12'd159:  chk("bar_x159", 32'(act[0].rgb), 32'hFFFFFF);
                12'd160:  chk("bar_x160", 32'(act[0].rgb), 32'hFFFF00);
                12'd1279: chk("bar_x1279", 32'(act[0].rgb), 32'h000000);
                default: ;
            endcase
        end

        // Medium instance: lines per frame and per-frame mode literals
        if (act[1].de && !prev_de_b) b_lines++;
        prev_de_b = act[1].de;
        if (act[1].fs) begin
            if (b_fr >= 1) chk("b_lines_per_frame", 32'(b_lines), 24);
            b_lines = 0;
            b_fr++;
        end
        if (act[1].de) begin
            if (b_fr == 1 && act[1].y == 20 && act[1].x == 0)
                chk("b_frame1_still_bar", 32'(act[1].rgb), 32'hFFFFFF);
            if (b_fr == 2 && act[1].y == 3 && act[1].x == 5)
                chk("b_solid", 32'(act[1].rgb), 32'h123456);
            if (b_fr == 3 && act[1].y == 5 && act[1].x == 16)
                chk("b_grid_16_5", 32'(act[1].rgb), 32'hFFFFFF);
            if (b_fr == 3 && act[1].y == 17 && act[1].x == 17)
                chk("b_grid_17_17", 32'(act[1].rgb), 32'h000000);
            if (b_fr == 4 && act[1].y == 0 && act[1].x == 300)
                chk("b_gradient_300", 32'(act[1].rgb), 32'h2C2C2C);
        end

        // Tiny instance: bar width 2, remainder clamp, scroll offset
        if (act[2].fs) c_fr++;
        if (act[2].de && act[2].y == 0) begin
            if (c_fr == 1 && act[2].x == 2)  chk("c_x2_bar1", 32'(act[2].rgb), 32'hFFFF00);
            if (c_fr == 1 && act[2].x == 18) chk("c_x18_bar7", 32'(act[2].rgb), 32'h000000);
            if (c_fr == 1 && act[2].x == 19) chk("c_x19_bar7", 32'(act[2].rgb), 32'h000000);
`ifdef VPG_SCROLL_EN
            if (c_fr == 4 && act[2].x == 0)  chk("c_scroll_x0", 32'(act[2].rgb), 32'hFFFF00);
`else
            if (c_fr == 4 && act[2].x == 0)  chk("c_static_x0", 32'(act[2].rgb), 32'hFFFFFF);
`endif
        end
    end

    initial begin
        bit seen;
        for (int d = 0; d < 3; d++) begin
            mode_in[d]  = 2'd0;
            solid_in[d] = 24'h0;
        end
        solid_in[1] = 24'h123456;
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5000) @(posedge clk);
        #2 mode_in[1] = 2'd3;
        repeat (10000) @(posedge clk);
        #2 mode_in[1] = 2'd1;
        repeat (10000) @(posedge clk);
        #2 mode_in[1] = 2'd2;
        repeat (21000) @(posedge clk);

        // Mid-line asynchronous reset on an active pixel of the tiny instance
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (o_de[2] && o_x[2] == 12'd10) seen = 1;
        end
        chk("wait_active_pixel", 32'(seen), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_de", 32'(o_de[2]), 0);
        chk("async_rst_rgb", 32'(o_rgb[2]), 0);
        chk("async_rst_x", 32'(o_x[2]), 0);
        chk("async_rst_hs_a", 32'(o_hs[0]), 0);
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_SYNC 40: hsync width in pixel clocks
  H_BACK 220: horizontal back porch
  H_DISP 1280: active pixels per line
  H_FRONT 110: horizontal front porch
  V_SYNC 5: vsync width in lines
  V_BACK 20: vertical back porch
  V_DISP 720: active lines per frame
  V_FRONT 5: vertical front porch
  COLOR_W 8: bits per colour channel
  CNT_W 12: width of counters and position outputs
REQ-002 Ports (name, direction, width, meaning):
  pixel_clk  in  1  pixel clock, the only clock
  sys_rst  in  1  asynchronous, active-high reset
  mode  in  2  pattern select: 0 colourbar, 1 grid, 2 gradient, 3 solid
  solid_rgb  in  3*COLOR_W  colour for mode 3, {R,G,B}
  video_hs  out  1  hsync, active high
  video_vs  out  1  vsync, active high
  video_de  out  1  data enable
  video_rgb  out  3*COLOR_W  pixel data, {R,G,B}
  pixel_xpos  out  CNT_W  active column
  pixel_ypos  out  CNT_W  active row
  frame_start  out  1  one-cycle pulse at the first cycle of each frame
REQ-003 The block SHALL use one clock (pixel_clk) and an asynchronous, active-high reset (sys_rst).

Function
REQ-004 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters) and wrap to 0; v_cnt SHALL advance by 1 when h_cnt wraps and SHALL wrap to 0 after V_TOTAL-1.
REQ-005 Timing order SHALL be: sync, back porch, active, front porch. hs SHALL be high for h_cnt < H_SYNC; vs SHALL be high for v_cnt < V_SYNC.
REQ-006 de SHALL be high for H_BACK+H_SYNC <= h_cnt < H_SYNC+H_BACK+H_DISP, with v_cnt in the matching vertical window.
REQ-007 All outputs SHALL be registered with a latency of one cycle after the counter state, and SHALL be mutually aligned.
REQ-008 While de is high, pixel_xpos/pixel_ypos SHALL equal the active column/row, counted from 0. Otherwise they SHALL be 0.
REQ-009 video_rgb SHALL be 0 whenever video_de is low.
REQ-010 mode and solid_rgb SHALL be captured only when h_cnt==0 and v_cnt==0. Changes mid-frame SHALL take effect at the next frame start.
REQ-011 frame_start SHALL pulse for exactly one cycle, aligned with the first video_vs-high cycle.
REQ-012 Mode 0 (colourbar) SHALL use bar width BW = H_DISP/8 (integer division). Bar index = x/BW, clamped to 7, so remainder pixels take bar 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or 0.
REQ-013 Mode 1 (grid) SHALL output white where x[3:0]==0 or y[3:0]==0, and black elsewhere.
REQ-014 Mode 2 (gradient) SHALL set R=G=B=x[COLOR_W-1:0], wrapping every 2^COLOR_W columns.
REQ-015 Mode 3 SHALL output the captured solid_rgb.

Reset
REQ-016 While sys_rst is high: counters, captured mode/solid colour and the scroll offset SHALL be 0; all outputs SHALL be 0.
REQ-017 After sys_rst deasserts, the first frame SHALL start from h_cnt=0, v_cnt=0. Reset asserted mid-frame SHALL abort the frame immediately.

Configuration
REQ-018 With VPG_SCROLL_EN defined: a CNT_W offset SHALL increment at each frame start and wrap from H_DISP-1 to 0. The colourbar SHALL use column (x+offset) mod H_DISP.
REQ-019 Without VPG_SCROLL_EN: no offset register SHALL exist, and the colourbar SHALL be static. Modes 1-3 SHALL be unaffected in both builds.

Verification
REQ-020 Reset: hold sys_rst high for 10 cycles -> all outputs 0. After release, frame_start pulses once and video_vs goes high on the same cycle.
REQ-021 Default timing: hs period 1650 cycles, hs high 40 cycles. de high for 1280 consecutive cycles per line and on 720 lines per frame. vs period 1650*750 cycles.
REQ-022 Colourbar, static build: row 0 -> x=0 gives 0xFFFFFF, x=160 gives 0xFFFF00, x=1279 gives 0x000000. video_rgb is 0 outside de.
REQ-023 Mode change: switch mode 0->3 with solid_rgb=0x123456 at line 100 -> the current frame stays colourbar; the next frame is all 0x123456 during de.
REQ-024 Grid: (x,y)=(16,5) -> 0xFFFFFF; (17,17) -> 0x000000. Gradient: x=300 -> 0x2C2C2C.
REQ-025 Small parameters (H_DISP=20, V_DISP=4, all porches and syncs 2), scroll build: BW=2; x=18,19 take bar 7; after 3 frames, x=0 shows bar 1. Assert sys_rst at mid-line -> outputs go to 0 asynchronously.
